// File: rtl/cu_param.sv
// ============================================================================
// cu_param -- parametrised multi-cycle control unit for the accumulator CPU
//
// Decodes the 4-bit opcode held in the instruction register and sequences
// the datapath strobes (PC, IR, A register, ALU, output latch, memory).
// Memory-dependent steps (instruction fetch and operand read) can be
// stretched by MEM_WAIT wait cycles. INPUT uses an Enter press/release
// handshake so that one press of the operator switch loads A exactly once.
//
// Parameters
//   MEM_WAIT   : wait cycles before each memory-dependent step (0..15)
//   WAIT_W     : wait counter width, 2**WAIT_W must exceed MEM_WAIT
//   ENTER_SYNC : 1 = Enter goes through a 2-flop synchroniser, 0 = used raw
//
// Build option
//   CU_ILLEGAL_TRAP_EN : when defined, opcode 15 enters TRAP (Err=1, Halt=1,
//                        terminal until reset). When undefined, opcode 15
//                        behaves as NOP and Err is constant 0.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   Enter        in   operator input-ready switch
//   Aeq0, Apos   in   accumulator flags (A == 0, A > 0)
//   IR[3:0]      in   opcode field of the instruction register
//   IRload, PCload, JMPmux, Meminst, MemWr, Aload, Oload
//                out  datapath strobes
//   Asel[1:0]    out  A input select: 00 ALU, 01 input port, 10 memory
//   ALUop[2:0]   out  000 pass-B, 001 add, 010 sub, 011 and, 100 or, 101 not-A
//   Halt         out  processor halted
//   Err          out  illegal-opcode trap
//   DisplayState out  current state code
// ============================================================================
module cu_param #(
    parameter int MEM_WAIT   = 0,
    parameter int WAIT_W     = 4,
    parameter int ENTER_SYNC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Enter,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic [3:0] IR,
    output logic       IRload,
    output logic       PCload,
    output logic       JMPmux,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Oload,
    output logic [1:0] Asel,
    output logic [2:0] ALUop,
    output logic       Halt,
    output logic       Err,
    output logic [4:0] DisplayState
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_LOAD    = 4'd0;
    localparam logic [3:0] OP_STORE   = 4'd1;
    localparam logic [3:0] OP_ADD     = 4'd2;
    localparam logic [3:0] OP_SUB     = 4'd3;
    localparam logic [3:0] OP_INPUT   = 4'd4;
    localparam logic [3:0] OP_JZ      = 4'd5;
    localparam logic [3:0] OP_JPOS    = 4'd6;
    localparam logic [3:0] OP_HALT    = 4'd7;
    localparam logic [3:0] OP_AND     = 4'd8;
    localparam logic [3:0] OP_OR      = 4'd9;
    localparam logic [3:0] OP_NOTA    = 4'd10;
    localparam logic [3:0] OP_JMP     = 4'd11;
    localparam logic [3:0] OP_OUT     = 4'd12;
    localparam logic [3:0] OP_JNEG    = 4'd13;
    localparam logic [3:0] OP_NOP     = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    // ------------------------------------------------------------------
    // State codes (visible on DisplayState)
    // ------------------------------------------------------------------
    localparam logic [4:0] S_START  = 5'd0;
    localparam logic [4:0] S_FWAIT  = 5'd1;
    localparam logic [4:0] S_FETCH  = 5'd2;
    localparam logic [4:0] S_DECODE = 5'd3;
    localparam logic [4:0] S_DWAIT  = 5'd4;
    localparam logic [4:0] S_LOAD   = 5'd5;
    localparam logic [4:0] S_STORE  = 5'd6;
    localparam logic [4:0] S_ADD    = 5'd7;
    localparam logic [4:0] S_SUB    = 5'd8;
    localparam logic [4:0] S_AND    = 5'd9;
    localparam logic [4:0] S_OR     = 5'd10;
    localparam logic [4:0] S_NOTA   = 5'd11;
    localparam logic [4:0] S_INPUT  = 5'd12;
    localparam logic [4:0] S_INREL  = 5'd13;
    localparam logic [4:0] S_JZ     = 5'd14;
    localparam logic [4:0] S_JPOS   = 5'd15;
    localparam logic [4:0] S_JNEG   = 5'd16;
    localparam logic [4:0] S_JMP    = 5'd17;
    localparam logic [4:0] S_OUT    = 5'd18;
    localparam logic [4:0] S_HALT   = 5'd19;
    localparam logic [4:0] S_TRAP   = 5'd20;

    // ------------------------------------------------------------------
    // Datapath encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_MEM = 2'b10;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_NOTA  = 3'b101;

    // Wait states are only reachable when MEM_WAIT > 0; the terminal count
    // is clamped to 0 otherwise so the constant stays in range.
    localparam bit                HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_WAIT > 0) ? WAIT_W'(MEM_WAIT - 1) : '0;

    localparam int SYNC_STAGES = 2;

    // ------------------------------------------------------------------
    // Enter conditioning
    // ------------------------------------------------------------------
    logic enter_sync;

    generate
        if (ENTER_SYNC != 0) begin : g_enter_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [SYNC_STAGES-1:0] sync_next;

            // Each stage samples the one before it; stage 0 samples the pin.
            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    assign sync_next[gi] = Enter;
                end else begin : g_chain
                    assign sync_next[gi] = sync_reg[gi-1];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= sync_next;
                end
            end

            assign enter_sync = sync_reg[SYNC_STAGES-1];
        end else begin : g_enter_raw
            assign enter_sync = Enter;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Opcode decode: execute state and whether a memory operand is read
    // ------------------------------------------------------------------
    logic [4:0] exec_state;
    logic       mem_op;

    always_comb begin
        exec_state = S_START;
        mem_op     = 1'b0;
        case (IR)
            OP_LOAD:    begin exec_state = S_LOAD;  mem_op = 1'b1; end
            OP_STORE:   exec_state = S_STORE;
            OP_ADD:     begin exec_state = S_ADD;   mem_op = 1'b1; end
            OP_SUB:     begin exec_state = S_SUB;   mem_op = 1'b1; end
            OP_INPUT:   exec_state = S_INPUT;
            OP_JZ:      exec_state = S_JZ;
            OP_JPOS:    exec_state = S_JPOS;
            OP_HALT:    exec_state = S_HALT;
            OP_AND:     begin exec_state = S_AND;   mem_op = 1'b1; end
            OP_OR:      begin exec_state = S_OR;    mem_op = 1'b1; end
            OP_NOTA:    exec_state = S_NOTA;
            OP_JMP:     exec_state = S_JMP;
            OP_OUT:     exec_state = S_OUT;
            OP_JNEG:    exec_state = S_JNEG;
            OP_NOP:     exec_state = S_START;
`ifdef CU_ILLEGAL_TRAP_EN
            OP_ILLEGAL: exec_state = S_TRAP;
`else
            OP_ILLEGAL: exec_state = S_START;
`endif
            default:    exec_state = S_START;
        endcase
    end

    // ------------------------------------------------------------------
    // State, wait counter and latched execute target
    // ------------------------------------------------------------------
    logic [4:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    // Execute target captured in DECODE so DWAIT does not depend on IR
    // staying stable through the operand wait.
    logic [4:0]        exec_reg, exec_next;
    logic              wait_done;

    assign wait_done = (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;          // counter is 0 on entry to any wait state
        exec_next     = exec_reg;
        case (state_reg)
            S_START: state_next = HAS_WAIT ? S_FWAIT : S_FETCH;
            S_FWAIT: begin
                if (wait_done) begin
                    state_next = S_FETCH;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                exec_next = exec_state;
                if (mem_op && HAS_WAIT) begin
                    state_next = S_DWAIT;
                end else begin
                    state_next = exec_state;
                end
            end
            S_DWAIT: begin
                if (wait_done) begin
                    state_next = exec_reg;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            S_LOAD, S_STORE, S_ADD, S_SUB, S_AND, S_OR, S_NOTA,
            S_JZ, S_JPOS, S_JNEG, S_JMP, S_OUT:
                state_next = S_START;
            // Load A continuously until the (synchronised) press is seen,
            // then wait for release so one press yields one INPUT.
            S_INPUT: if (enter_sync)  state_next = S_INREL;
            S_INREL: if (!enter_sync) state_next = S_START;
            S_HALT:  state_next = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
            S_TRAP:  state_next = S_TRAP;
`else
            S_TRAP:  state_next = S_START;
`endif
            default: state_next = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_START;
            wait_cnt_reg <= '0;
            exec_reg     <= S_START;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            exec_reg     <= exec_next;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs; conditional jumps gate PCload with the live flags
    // ------------------------------------------------------------------
    always_comb begin
        IRload  = 1'b0;
        PCload  = 1'b0;
        JMPmux  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Aload   = 1'b0;
        Oload   = 1'b0;
        Asel    = ASEL_ALU;
        ALUop   = ALU_PASSB;
        Halt    = 1'b0;
        Err     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            S_DECODE, S_DWAIT: Meminst = 1'b1;
            S_LOAD: begin
                Meminst = 1'b1;
                Asel    = ASEL_MEM;
                Aload   = 1'b1;
                ALUop   = ALU_PASSB;
            end
            S_STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            S_ADD: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                ALUop   = ALU_ADD;
            end
            S_SUB: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                ALUop   = ALU_SUB;
            end
            S_AND: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                ALUop   = ALU_AND;
            end
            S_OR: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                ALUop   = ALU_OR;
            end
            S_NOTA: begin
                Aload = 1'b1;
                ALUop = ALU_NOTA;
            end
            S_INPUT: begin
                Asel  = ASEL_IN;
                Aload = 1'b1;
            end
            S_JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            S_JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            S_JNEG: begin
                JMPmux = 1'b1;
                PCload = !Aeq0 && !Apos;   // negative: neither zero nor positive
            end
            S_JMP: begin
                JMPmux = 1'b1;
                PCload = 1'b1;
            end
            S_OUT:  Oload = 1'b1;
            S_HALT: Halt  = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
            S_TRAP: begin
                Halt = 1'b1;
                Err  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign DisplayState = state_reg;

endmodule
